// File: rtl/nibble_cpu_gen2.sv
// nibble_cpu_gen2: nibble-serial CPU with DATA_W-bit A/B registers, ADDR_W-bit PC,
// carry flag and a circular return stack. Memory is external, one nibble per
// address, read combinationally through din.
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | idle cycle between instructions (skipped when fast=1)
// OP      | opcode nibble on din; ALU ops execute here
// SUB     | sub-op nibble after opcode 8
// ADR     | collecting address nibbles, MSB first; resolves on the last
// LD      | reading data nibbles from tmp+k into A or B, MSB first
// ST      | writing data nibbles of A or B to tmp+k, MSB first
module nibble_cpu_gen2 #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int STACK_D = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        din,
  input  logic              fast,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        dout,
  output logic              we,
  output logic              op_fetch,
  output logic              stk_err
);

  localparam int ND  = DATA_W / 4;
  localparam int NA  = (ADDR_W + 3) / 4;
  localparam int SW  = $clog2(DATA_W);
  localparam int KW  = (ND > 1) ? $clog2(ND) : 1;
  localparam int CW  = (NA > 1) ? $clog2(NA) : 1;
  localparam int PW  = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam int SPW = $clog2(STACK_D + 1);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_OP    = 3'd1;
  localparam logic [2:0] S_SUB   = 3'd2;
  localparam logic [2:0] S_ADR   = 3'd3;
  localparam logic [2:0] S_LD    = 3'd4;
  localparam logic [2:0] S_ST    = 3'd5;

  // ir holds the pending opcode while in ADR/LD/ST; CALL is tagged as 8,
  // which can never be a pending top-level opcode since 8 always means SUB.
  localparam logic [3:0] IR_CALL = 4'h8;

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] a_q, b_q;
  logic              c_q;
  logic [ADDR_W-1:0] tmp;
  logic [3:0]        ir;
  logic [CW-1:0]     cnt;
  logic [KW-1:0]     k;
  logic [SPW-1:0]    sp;
  logic [PW-1:0]     wp;
  logic [ADDR_W-1:0] stack_q [STACK_D];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W+3:0] tmp_cat;
  logic [ADDR_W-1:0] tgt;
  logic              adr_last, data_last;
  logic [2:0]        end_state;
  logic [PW-1:0]     wp_inc, wp_dec;
  logic              push_en;
  logic [SW-1:0]     shamt;
  logic [DATA_W:0]   sum_add, sum_adc;
  logic [DATA_W-1:0] alu_a;
  logic              alu_c;
  logic [DATA_W-1:0] st_reg, ld_val;
  logic [KW-1:0]     nib_idx;
  logic [3:0]        st_nib;

  assign pc_inc    = pc + 1'b1;
  assign tmp_cat   = {tmp, din};
  assign tgt       = tmp_cat[ADDR_W-1:0];
  assign adr_last  = (cnt == CW'(NA - 1));
  assign data_last = (k == KW'(ND - 1));
  assign end_state = fast ? S_OP : S_FETCH;
  assign wp_inc    = (wp == PW'(STACK_D - 1)) ? '0 : wp + 1'b1;
  assign wp_dec    = (wp == '0) ? PW'(STACK_D - 1) : wp - 1'b1;
  assign push_en   = (state == S_ADR) && adr_last && (ir == IR_CALL);

  assign shamt   = b_q[SW-1:0];
  assign sum_add = {1'b0, a_q} + {1'b0, b_q};
  assign sum_adc = sum_add + {{DATA_W{1'b0}}, c_q};

  // ALU result for the opcode on din; shifts by >= DATA_W fall out of the
  // native shift semantics as zero or sign fill.
  always_comb begin
    alu_a = a_q;
    alu_c = c_q;
    case (din[2:0])
      3'd0: alu_a = -a_q;
      3'd1: alu_a = a_q & b_q;
      3'd2: alu_a = a_q | b_q;
      3'd3: alu_a = a_q ^ b_q;
      3'd4: alu_a = a_q << shamt;
      3'd5: alu_a = a_q >> shamt;
      3'd6: alu_a = $unsigned($signed(a_q) >>> shamt);
      default: begin
        alu_a = sum_add[DATA_W-1:0];
        alu_c = sum_add[DATA_W];
      end
    endcase
  end

  // Nibble select/replace for LD/ST: nibble ND-1-k lives at address tmp+k.
  always_comb begin
    st_reg  = ir[0] ? b_q : a_q;
    nib_idx = KW'(ND - 1) - k;
    st_nib  = st_reg[{nib_idx, 2'b00} +: 4];
    ld_val  = st_reg;
    ld_val[{nib_idx, 2'b00} +: 4] = din;
  end

  // Main sequencer and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pc      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      tmp     <= '0;
      ir      <= '0;
      cnt     <= '0;
      k       <= '0;
      sp      <= '0;
      wp      <= '0;
      stk_err <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_OP;
        S_OP: begin
          pc <= pc_inc;
          if (!din[3]) begin
            a_q   <= alu_a;
            c_q   <= alu_c;
            state <= end_state;
          end else if (din == 4'h8) begin
            state <= S_SUB;
          end else begin
            ir    <= din;
            cnt   <= '0;
            state <= S_ADR;
          end
        end
        S_SUB: begin
          pc    <= pc_inc;
          state <= end_state;
          case (din)
            4'h1: begin
              ir    <= IR_CALL;
              cnt   <= '0;
              state <= S_ADR;
            end
            4'h2: begin
              if (sp == '0) begin
                stk_err <= 1'b1;
              end else begin
                pc <= stack_q[wp_dec];
                sp <= sp - 1'b1;
                wp <= wp_dec;
              end
            end
            4'h3: begin
              a_q <= b_q;
              b_q <= a_q;
            end
            4'h4: c_q <= 1'b0;
            4'h5: begin
              a_q <= sum_adc[DATA_W-1:0];
              c_q <= sum_adc[DATA_W];
            end
            default: ;
          endcase
        end
        S_ADR: begin
          pc  <= pc_inc;
          tmp <= tgt;
          cnt <= cnt + 1'b1;
          if (adr_last) begin
            k     <= '0;
            state <= end_state;
            case (ir)
              4'h9: if (a_q == b_q) pc <= pc_inc + tgt;
              4'hA: if (a_q <= b_q) pc <= pc_inc + tgt;
              4'hB: pc <= tgt;
              IR_CALL: begin
                pc <= tgt;
                wp <= wp_inc;
                if (sp == SPW'(STACK_D)) stk_err <= 1'b1;
                else                     sp <= sp + 1'b1;
              end
              4'hC, 4'hD: state <= S_LD;
              4'hE, 4'hF: state <= S_ST;
              default: ;
            endcase
          end
        end
        S_LD: begin
          if (ir[0]) b_q <= ld_val;
          else       a_q <= ld_val;
          k <= k + 1'b1;
          if (data_last) state <= end_state;
        end
        S_ST: begin
          k <= k + 1'b1;
          if (data_last) state <= end_state;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Return-stack storage; a push at full depth overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[wp] <= pc_inc;
  end

  assign addr     = (state == S_LD || state == S_ST) ? tmp + ADDR_W'(k) : pc;
  assign we       = (state == S_ST);
  assign dout     = (state == S_ST) ? st_nib : 4'h0;
  assign op_fetch = (state == S_OP);

endmodule

// File: tb/tb_nibble_cpu_gen2.sv
// Testbench for nibble_cpu_gen2 (DATA_W=8, ADDR_W=8, STACK_D=4): directed
// scenarios plus random programs checked against an instruction-level model.
module tb_nibble_cpu_gen2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       fast  = 1'b0;
  logic [3:0] din;
  logic [7:0] addr;
  logic [3:0] dout;
  logic       we;
  logic       op_fetch;
  logic       stk_err;

  logic [3:0] mem [256];
  assign din = mem[addr];

  always #5 clk = ~clk;

  nibble_cpu_gen2 #(.DATA_W(8), .ADDR_W(8), .STACK_D(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .fast(fast), .addr(addr),
    .dout(dout), .we(we), .op_fetch(op_fetch), .stk_err(stk_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] wa [$];
  logic [3:0] wd [$];

  // reference model state
  logic [3:0] mm [256];
  int ma, mb, mc, mpc, merr;
  int mstk [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: called and returns at negedge; memory write on the posedge
  task automatic tick();
    logic       w;
    logic [7:0] a;
    logic [3:0] d;
    w = we; a = addr; d = dout;
    @(posedge clk);
    if (w === 1'b1) begin
      mem[a] <= d;
      wa.push_back(a);
      wd.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 4'h0;
    wa.delete();
    wd.delete();
  endtask

  task automatic prog(input int base, input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      mem[(base + i) & 255] = (c >= "A") ? 4'(c - "A" + 10) : 4'(c - "0");
    end
  endtask

  task automatic next_op(output logic [7:0] a);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!op_fetch && n < 200);
    check("op_timeout", {31'd0, op_fetch}, 32'd1);
    a = addr;
  endtask

  task automatic run_until(input logic [7:0] target);
    logic [7:0] a;
    int n;
    n = 0;
    do begin
      next_op(a);
      n++;
    end while (a != target && n < 60);
    check("run_target", {24'd0, a}, {24'd0, target});
  endtask

  // ---------------- instruction-level reference model ----------------
  function automatic int rd2(input int p);
    return mm[p & 255] * 16 + mm[(p + 1) & 255];
  endfunction

  task automatic iss_step();
    int op, sub, t, s, sum, sa;
    op  = mm[mpc];
    mpc = (mpc + 1) & 255;
    if (op < 8) begin
      s = mb & 7;
      case (op)
        0: ma = (-ma) & 255;
        1: ma = ma & mb;
        2: ma = ma | mb;
        3: ma = ma ^ mb;
        4: ma = (ma << s) & 255;
        5: ma = ma >> s;
        6: begin
          sa = (ma >= 128) ? ma - 256 : ma;
          ma = (sa >>> s) & 255;
        end
        default: begin
          sum = ma + mb;
          mc  = sum >> 8;
          ma  = sum & 255;
        end
      endcase
    end else if (op == 8) begin
      sub = mm[mpc];
      mpc = (mpc + 1) & 255;
      case (sub)
        1: begin
          t   = rd2(mpc);
          mpc = (mpc + 2) & 255;
          if (mstk.size() == 4) begin
            void'(mstk.pop_front());
            merr = 1;
          end
          mstk.push_back(mpc);
          mpc = t;
        end
        2: if (mstk.size() == 0) merr = 1; else mpc = mstk.pop_back();
        3: begin sa = ma; ma = mb; mb = sa; end
        4: mc = 0;
        5: begin
          sum = ma + mb + mc;
          mc  = sum >> 8;
          ma  = sum & 255;
        end
        default: ;
      endcase
    end else begin
      t   = rd2(mpc);
      mpc = (mpc + 2) & 255;
      case (op)
        9:  if (ma == mb) mpc = (mpc + t) & 255;
        10: if (ma <= mb) mpc = (mpc + t) & 255;
        11: mpc = t;
        12: ma = rd2(t);
        13: mb = rd2(t);
        14: begin mm[t] = 4'(ma >> 4); mm[(t + 1) & 255] = 4'(ma); end
        default: begin mm[t] = 4'(mb >> 4); mm[(t + 1) & 255] = 4'(mb); end
      endcase
    end
  endtask

  logic [7:0] lda_exp [7];
  logic [7:0] stk_exp [11];
  logic [7:0] a_obs;

  initial begin
    lda_exp = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h20, 8'h21, 8'h03};
    stk_exp = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h44, 8'h34, 8'h24, 8'h14, 8'h16};
    clear_mem();

    // reset values, asynchronously
    #1 rst_n = 1'b0;
    #1;
    check("rst_addr", {24'd0, addr}, 32'h0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_dout", {28'd0, dout}, 32'h0);
    check("rst_opf", {31'd0, op_fetch}, 32'd0);
    check("rst_err", {31'd0, stk_err}, 32'd0);
    @(negedge clk);

    // LDA with addressing sequence, then STA to observe A
    clear_mem();
    prog('h00, "C20E80B06");
    prog('h20, "3C");
    do_reset();
    for (int i = 0; i < 7; i++) begin
      check("lda_addr", {24'd0, addr}, {24'd0, lda_exp[i]});
      if (i == 6) check("lda_fetch", {31'd0, op_fetch}, 32'd0);
      tick();
    end
    next_op(a_obs);
    check("lda_halt", {24'd0, a_obs}, 32'h06);
    check("lda_hi", {28'd0, mem[8'h80]}, 32'h3);
    check("lda_lo", {28'd0, mem[8'h81]}, 32'hC);

    // carry: ADD, ADC, CLC
    clear_mem();
    prog('h00, "CE0DE27E9085E92CE078485E94B1A");
    prog('hE0, "F020");
    do_reset();
    run_until(8'h1A);
    check("add_a_hi", {28'd0, mem[8'h90]}, 32'h1);
    check("add_a_lo", {28'd0, mem[8'h91]}, 32'h0);
    check("adc_a_hi", {28'd0, mem[8'h92]}, 32'h3);
    check("adc_a_lo", {28'd0, mem[8'h93]}, 32'h1);
    check("clc_a_hi", {28'd0, mem[8'h94]}, 32'h3);
    check("clc_a_lo", {28'd0, mem[8'h95]}, 32'h0);

    // STB write strobes
    clear_mem();
    prog('h00, "DE0F40B06");
    prog('hE0, "A5");
    do_reset();
    run_until(8'h06);
    check("stb_nwr", wa.size(), 32'd2);
    check("stb_a0", {24'd0, wa[0]}, 32'h40);
    check("stb_d0", {28'd0, wd[0]}, 32'hA);
    check("stb_a1", {24'd0, wa[1]}, 32'h41);
    check("stb_d1", {28'd0, wd[1]}, 32'h5);

    // CALL/RET
    clear_mem();
    prog('h00, "B10");
    prog('h10, "8130");
    prog('h30, "82");
    prog('h14, "B14");
    do_reset();
    next_op(a_obs); check("cr_op0", {24'd0, a_obs}, 32'h00);
    next_op(a_obs); check("cr_op1", {24'd0, a_obs}, 32'h10);
    next_op(a_obs); check("cr_call", {24'd0, a_obs}, 32'h30);
    next_op(a_obs); check("cr_ret", {24'd0, a_obs}, 32'h14);

    // stack overflow / underflow
    clear_mem();
    prog('h00, "8110");
    prog('h10, "8120");
    prog('h20, "8130");
    prog('h30, "8140");
    prog('h40, "8150");
    prog('h50, "82");
    prog('h44, "82");
    prog('h34, "82");
    prog('h24, "82");
    prog('h14, "82B16");
    do_reset();
    for (int i = 0; i < 11; i++) begin
      next_op(a_obs);
      check("stk_op", {24'd0, a_obs}, {24'd0, stk_exp[i]});
      check("stk_err", {31'd0, stk_err}, (i >= 5) ? 32'd1 : 32'd0);
    end

    // BLE taken and not taken
    for (int r = 0; r < 2; r++) begin
      clear_mem();
      prog('h00, "CE0DE2B50");
      prog('h50, "A03B53");
      prog('h56, "B56");
      prog('hE0, (r == 0) ? "0505" : "0605");
      do_reset();
      for (int i = 0; i < 4; i++) next_op(a_obs);
      check("ble_at50", {24'd0, a_obs}, 32'h50);
      next_op(a_obs);
      check("ble_tgt", {24'd0, a_obs}, (r == 0) ? 32'h56 : 32'h53);
    end

    // fast mode: back-to-back ALU ops keep op_fetch high
    clear_mem();
    prog('h00, "1234567012345670");
    fast = 1'b1;
    do_reset();
    tick();
    for (int i = 0; i < 12; i++) begin
      check("fast_opf", {31'd0, op_fetch}, 32'd1);
      check("fast_addr", {24'd0, addr}, i);
      tick();
    end
    fast = 1'b0;

    // reset in the middle of a store
    clear_mem();
    prog('h00, "E40");
    prog('h40, "FF");
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check("mid_we_pre", {31'd0, we}, 32'd1);
    check("mid_addr_pre", {24'd0, addr}, 32'h40);
    rst_n = 1'b0;
    #1;
    check("mid_we", {31'd0, we}, 32'd0);
    check("mid_addr", {24'd0, addr}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    check("mid_rel_addr", {24'd0, addr}, 32'h0);
    check("mid_rel_fetch", {31'd0, op_fetch}, 32'd0);
    check("mid_mem", {28'd0, mem[8'h40]}, 32'hF);

    // random programs against the reference model
    for (int r = 0; r < 3; r++) begin
      int executed, cycles;
      clear_mem();
      for (int i = 0; i < 256; i++) begin
        mem[i] = 4'($urandom);
        mm[i]  = mem[i];
      end
      ma = 0; mb = 0; mc = 0; mpc = 0; merr = 0;
      mstk.delete();
      do_reset();
      executed = 0;
      cycles   = 0;
      while (1) begin
        if (op_fetch) begin
          check("rand_pc", {24'd0, addr}, mpc);
          check("rand_err", {31'd0, stk_err}, merr);
          if (executed == 250) break;
          iss_step();
          executed++;
        end
        if (cycles >= 5000) break;
        fast = 1'($urandom);
        tick();
        cycles++;
      end
      check("rand_done", executed, 32'd250);
      for (int i = 0; i < 256; i++) check("rand_mem", {28'd0, mem[i]}, {28'd0, mm[i]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
